sdram_frame_reader: RTL
=======================

# sdram_frame_reader

Read-side counterpart of the capture write path: pulls packed pixel pairs from the two SDRAM read FIFOs, unpacks them to 10-bit RGB, and drives VGA timing and pixel outputs. It generates its own raster counters, requests one FIFO word pair per active pixel with fixed read latency, and aligns all sync and blank outputs to the returned data. It also flags FIFO underflow and tells the SDRAM controller when to rewind the read address for the next frame.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- RD_LAT, 1, FIFO read-data latency in clocks after oRead; legal values 1 or 2
- iClk  in  1  pixel clock; the block has one clock
- iRst  in  1  reset; synchronous, active-high
- iEnable  in  1  streaming enable; sampled only at the frame-start point
- iRd_empty  in  1  high when either read FIFO is empty
- iRd1_data  in  16  {1'b0, G[9:5], B[9:0]}
- iRd2_data  in  16  {1'b0, G[4:0], R[9:0]}
- oRead  out  1  read request, one pair per cycle, to both FIFOs
- oFrame_start  out  1  one-cycle pulse; controller rewinds its read address
- oVGA_R / oVGA_G / oVGA_B  out  10 each  pixel colour
- oVGA_HS / oVGA_VS  out  1 each  syncs, active low
- oVGA_BLANK_n  out  1  high during active video
- oX_Cont / oY_Cont  out  16 each  coordinates of the pixel currently on the outputs
- oUnderflow  out  1  sticky underflow flag

## Operation
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800). v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1 (525).
- Region order on each axis: active, front porch, sync, back porch.
- Counters run continuously from reset, regardless of FSM state.
- FSM states and transitions:
  - IDLE -> ARMED when iEnable = 1.
  - ARMED -> STREAM at the frame-start point.
  - STREAM -> IDLE at the frame-start point if iEnable = 0.
  - ARMED -> IDLE if iEnable falls before the frame-start point.
- Frame-start point: h_cnt = 0, v_cnt = V_ACTIVE (start of vertical blanking). oFrame_start pulses there in ARMED and in STREAM.
- oRead = STREAM & active region & !iRd_empty.
- Underflow: in STREAM, an active pixel with iRd_empty = 1 sets oUnderflow until reset. That pixel is output black. Raster position is not slipped, and the next pixel reads normally.
- In IDLE and ARMED, active pixels are output black and sync timing continues.
- Unpack:
  - R = iRd2_data[9:0]
  - B = iRd1_data[9:0]
  - G = {iRd1_data[14:10], iRd2_data[14:10]}
  - Bit 15 of both words is ignored.
- Blanked pixels are forced to RGB = 0.

## Timing
- Pipeline: counters -> request stage -> RD_LAT clocks -> output register.
- Total latency from raster counter to pins is RD_LAT+1 clocks. HS, VS, BLANK_n, X and Y are delayed by the same amount, so they stay aligned to the colour data.
- A "pixel valid" bit (read issued) travels with the pipeline; when it is clear, the output pixel is black.
- Reset values:
  - All counters 0, FSM = IDLE.
  - oRead = 0, oFrame_start = 0, oUnderflow = 0.
  - RGB = 0, HS = 1, VS = 1, BLANK_n = 0, X = 0, Y = 0.
- Reset mid-frame: all of the above are restored on the next edge. In-flight pipeline valid bits are cleared, so no stale pixel appears.
- iEnable toggling mid-frame has no effect until the next frame-start point.

## Configuration
- SDRAM_FRAME_READER_UFCNT_EN defined:
  - Adds output oUnderflow_cnt[15:0], a saturating count of underflowed pixels.
  - Cleared by reset only; holds at 16'hFFFF once saturated.
- Not defined: the port and counter are absent, and oUnderflow behaves identically.

## Structure
- Shared package holds:
  - the default VGA timing constants and H_TOTAL/V_TOTAL derivation;
  - the FSM state typedef (IDLE, ARMED, STREAM);
  - the packed-word field positions shared with the write-side packer.
- One sub-module, vga_raster_gen: h/v counters, region decode and sync generation. The top level owns the FSM, FIFO handshake, delay pipeline and unpacking.

## Test plan
- Reset, then release with iEnable = 0. Required:
  - HS period 800 clocks with 96 clocks low; VS period 525 lines with 2 lines low.
  - BLANK_n high 640 clocks per line; RGB stays 0 and oRead never asserts.
- iEnable = 1 with FIFOs never empty. Required:
  - exactly one oFrame_start pulse, at h = 0, v = 480;
  - 307200 oRead cycles in the following frame, with no underflow.
- Unpack check: iRd1_data = 16'h7D55, iRd2_data = 16'h2AAA. Required: R = 10'h2AA, G = 10'h3EA, B = 10'h155 at the pins, RD_LAT+1 clocks after the request. Run with RD_LAT = 1 and RD_LAT = 2.
- iRd_empty = 1 for the single cycle of pixel (10, 5). Required:
  - that pixel is black and oUnderflow rises and stays high;
  - pixel (11, 5) carries FIFO data;
  - UFCNT build reads 1.
- Drop iEnable at line 100 of a streaming frame. Required: the frame completes with reads; FSM enters IDLE at the next frame-start point; no oFrame_start pulse follows.
- Assert iRst for one cycle mid-line during STREAM. Required: all outputs at reset values on the next edge; no stale pixel emerges from the pipeline afterwards.

Source files
------------

// File: rtl/sdram_frame_reader_pkg.sv
// sdram_frame_reader_pkg: VGA timing defaults, FSM states, pipeline record and packed-pixel field layout
package sdram_frame_reader_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_RD_LAT = 1;
  localparam int COLOR_W = 10;
  localparam int G_HALF_W = 5;
  localparam int G_HALF_LSB = 10;
  function automatic int span4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
  localparam int DEF_H_TOTAL = span4(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span4(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  typedef enum logic [1:0] {IDLE, ARMED, STREAM} state_t;
  typedef struct packed {
    logic vld;
    logic hs;
    logic vs;
    logic de;
    logic [15:0] x;
    logic [15:0] y;
  } pix_t;
  localparam pix_t PIX_RST = '{vld: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, x: 16'd0, y: 16'd0};
  function automatic logic [3*COLOR_W-1:0] unpack_rgb(input logic [15:0] w1, input logic [15:0] w2);
    return {w2[COLOR_W-1:0], w1[G_HALF_LSB +: G_HALF_W], w2[G_HALF_LSB +: G_HALF_W], w1[COLOR_W-1:0]};
  endfunction
endpackage

// File: rtl/sdram_frame_reader_if.sv
// sdram_frame_reader_if: FIFO handshake and VGA pins; oUnderflow_cnt exists only with SDRAM_FRAME_READER_UFCNT_EN
interface sdram_frame_reader_if;
  logic iEnable;
  logic iRd_empty;
  logic [15:0] iRd1_data;
  logic [15:0] iRd2_data;
  logic oRead;
  logic oFrame_start;
  logic [9:0] oVGA_R;
  logic [9:0] oVGA_G;
  logic [9:0] oVGA_B;
  logic oVGA_HS;
  logic oVGA_VS;
  logic oVGA_BLANK_n;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic oUnderflow;
`ifdef SDRAM_FRAME_READER_UFCNT_EN
  logic [15:0] oUnderflow_cnt;
`endif
  modport slave(
    input iEnable, iRd_empty, iRd1_data, iRd2_data,
    output oRead, oFrame_start, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_n,
    oX_Cont, oY_Cont, oUnderflow
`ifdef SDRAM_FRAME_READER_UFCNT_EN
    , oUnderflow_cnt
`endif
  );
  modport master(
    output iEnable, iRd_empty, iRd1_data, iRd2_data,
    input oRead, oFrame_start, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_n,
    oX_Cont, oY_Cont, oUnderflow
`ifdef SDRAM_FRAME_READER_UFCNT_EN
    , oUnderflow_cnt
`endif
  );
endinterface

// File: rtl/sdram_frame_reader_vga_raster_gen.sv
// vga_raster_gen: free-running h/v counters with active, sync and frame-start decode
module vga_raster_gen import sdram_frame_reader_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_h,
  output logic [15:0] o_v,
  output logic        o_active,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_fs
);
  localparam logic [15:0] H_LAST = 16'(span4(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [15:0] V_LAST = 16'(span4(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [15:0] H_ACT = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT = 16'(V_ACTIVE);
  localparam logic [15:0] HS_ON = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_OFF = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_ON = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_OFF = 16'(V_ACTIVE + V_FP + V_SYNC);
  logic [15:0] r_h, r_v;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= (r_h == H_LAST) ? '0 : r_h + 16'd1;
      if (r_h == H_LAST) r_v <= (r_v == V_LAST) ? '0 : r_v + 16'd1;
    end
  assign o_h = r_h;
  assign o_v = r_v;
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hs = !((r_h >= HS_ON) && (r_h < HS_OFF));
  assign o_vs = !((r_v >= VS_ON) && (r_v < VS_OFF));
  assign o_fs = (r_h == '0) && (r_v == V_ACT);
endmodule

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: FIFO pixel-pair reader to VGA; SDRAM_FRAME_READER_UFCNT_EN adds oUnderflow_cnt
module sdram_frame_reader import sdram_frame_reader_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input logic iClk,
  input logic iRst,
  sdram_frame_reader_if.slave bus
);
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end
  logic [15:0] w_h, w_v;
  logic w_act, w_hs, w_vs, w_fs, w_stream, w_read, w_uf;
  state_t r_state;
  pix_t w_pix, r_out;
  pix_t r_pipe [RD_LAT];
  logic [3*COLOR_W-1:0] r_rgb;
  logic r_uf;
  vga_raster_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .i_clk(iClk), .i_rst(iRst), .o_h(w_h), .o_v(w_v),
    .o_active(w_act), .o_hs(w_hs), .o_vs(w_vs), .o_fs(w_fs)
  );
  assign w_stream = r_state == STREAM;
  assign w_read = w_stream & w_act & ~bus.iRd_empty;
  assign w_uf = w_stream & w_act & bus.iRd_empty;
  assign w_pix = '{vld: w_read, hs: w_hs, vs: w_vs, de: w_act, x: w_h, y: w_v};
  always_ff @(posedge iClk)
    if (iRst) r_state <= IDLE;
    else
      unique case (r_state)
        IDLE: if (bus.iEnable) r_state <= ARMED;
        ARMED: r_state <= !bus.iEnable ? IDLE : w_fs ? STREAM : ARMED;
        STREAM: if (w_fs && !bus.iEnable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
  // sideband travels RD_LAT stages alongside the read so it meets the returned data
  always_ff @(posedge iClk)
    if (iRst) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= PIX_RST;
      r_out <= PIX_RST;
      r_rgb <= '0;
    end else begin
      r_pipe[0] <= w_pix;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_out <= r_pipe[RD_LAT-1];
      r_rgb <= (r_pipe[RD_LAT-1].vld && r_pipe[RD_LAT-1].de) ? unpack_rgb(bus.iRd1_data, bus.iRd2_data) : '0;
    end
  always_ff @(posedge iClk) r_uf <= iRst ? 1'b0 : (r_uf | w_uf);
`ifdef SDRAM_FRAME_READER_UFCNT_EN
  logic [15:0] r_ufcnt;
  always_ff @(posedge iClk) r_ufcnt <= iRst ? '0 : (w_uf && r_ufcnt != 16'hFFFF) ? r_ufcnt + 16'd1 : r_ufcnt;
  assign bus.oUnderflow_cnt = r_ufcnt;
`endif
  assign bus.oRead = w_read;
  assign bus.oFrame_start = w_fs & (w_stream | (r_state == ARMED & bus.iEnable));
  assign {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B} = r_rgb;
  assign bus.oVGA_HS = r_out.hs;
  assign bus.oVGA_VS = r_out.vs;
  assign bus.oVGA_BLANK_n = r_out.de;
  assign bus.oX_Cont = r_out.x;
  assign bus.oY_Cont = r_out.y;
  assign bus.oUnderflow = r_uf;
endmodule
